// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single memory-controller request port between the
// CPU (port 0) and the UART program loader (port 1). Transactions are serialised
// through IDLE -> ISSUE -> WAIT -> DONE. The controller request is held until the
// matching completion arrives, then read data and a one-cycle ack go to the owner.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a WAIT watchdog and the sticky
// timeout_err output port.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_type,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_type,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mc_request,
  output logic              mc_request_type,
  output logic [ADDR_W-1:0] mc_request_address,
  output logic [DATA_W-1:0] mc_memory_write,
  input  logic [DATA_W-1:0] mc_data_out,
  input  logic              mc_memory_ready,
  input  logic              mc_write_complete,
  output logic [1:0]        grant,
  output logic              busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  // Watchdog counter width; the limit TIMEOUT_CYCLES-1 must fit in it.
  localparam int unsigned CNT_W = 13;

  // Reject watchdog limits the 13-bit counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 8192) begin : g_bad_timeout
    $error("mem_req_arbiter: TIMEOUT_CYCLES out of range 2..8192");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mc_request;
  logic                r_ack0;
  logic                r_ack1;
  logic [1:0]          r_grant;
  logic                r_busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]    r_to_cnt;
  logic                r_timeout_err;
`endif

  logic                w_win_valid;
  logic                w_win_port;
  logic                w_done;

  // Winner selection from the level-sampled requests (used only in IDLE).
  always_comb begin
    w_win_valid = r0_req | r1_req;
    w_win_port  = 1'b0;
    if (FIXED_PRIORITY != 0) begin
      w_win_port = ~r0_req;
    end else if (r0_req && r1_req) begin
      if (!r_last_grant && r0_lock) begin
        w_win_port = 1'b0;
      end else begin
        w_win_port = ~r_last_grant;
      end
    end else begin
      w_win_port = r1_req;
    end
  end

  // Only the completion matching the latched transaction type counts.
  always_comb begin
    w_done = r_type ? mc_write_complete : mc_memory_ready;
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_type        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_mc_request  <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_grant       <= 2'b00;
      r_busy        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            if (w_win_port) begin
              r_type  <= r1_type;
              r_addr  <= r1_addr;
              r_wdata <= r1_wdata;
              r_grant <= 2'b10;
            end else begin
              r_type  <= r0_type;
              r_addr  <= r0_addr;
              r_wdata <= r0_wdata;
              r_grant <= 2'b01;
            end
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mc_request <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          r_to_cnt     <= '0;
`endif
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            if (!r_type) begin
              r_rdata <= mc_data_out;
            end
            r_mc_request <= 1'b0;
            r_ack0       <= r_grant[0];
            r_ack1       <= r_grant[1];
            r_last_grant <= r_grant[1];
            r_state      <= ST_DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_rdata       <= '0;
            r_mc_request  <= 1'b0;
            r_ack0        <= r_grant[0];
            r_ack1        <= r_grant[1];
            r_last_grant  <= r_grant[1];
            r_timeout_err <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign r0_ack             = r_ack0;
  assign r1_ack             = r_ack1;
  assign rdata              = r_rdata;
  assign mc_request         = r_mc_request;
  assign mc_request_type    = r_type;
  assign mc_request_address = r_addr;
  assign mc_memory_write    = r_wdata;
  assign grant              = r_grant;
  assign busy               = r_busy;
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err        = r_timeout_err;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: the stimulus process drives requesters and
// predicts each transaction (winner, controller fields, returned rdata); a controller
// model answers mc_request and checks the request fields; a monitor checks acks.
module tb_mem_req_arbiter;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 16;
  localparam int          TO_CYC = 16;

  typedef struct {
    int          port;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    int          port;
    bit          typ;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    bit          hang;
    bit          spur;
    int          issue_cyc;
  } ctrl_t;

  logic          clk;
  logic          reset;
  logic          r0_req, r0_type, r0_lock, r0_ack;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_req, r1_type, r1_ack;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] rdata;
  logic          mc_request, mc_request_type;
  logic [AW-1:0] mc_request_address;
  logic [DW-1:0] mc_memory_write;
  logic [DW-1:0] mc_data_out;
  logic          mc_memory_ready, mc_write_complete;
  logic [1:0]    grant;
  logic          busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          model_last = 1;
  logic [15:0] model_rdata = 16'h0000;

  exp_t  exp_q[$];
  ctrl_t ctrl_q[$];
  int    done_q[$];

  mem_req_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .FIXED_PRIORITY(0),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .r0_req(r0_req),
    .r0_type(r0_type),
    .r0_addr(r0_addr),
    .r0_wdata(r0_wdata),
    .r0_lock(r0_lock),
    .r0_ack(r0_ack),
    .r1_req(r1_req),
    .r1_type(r1_type),
    .r1_addr(r1_addr),
    .r1_wdata(r1_wdata),
    .r1_ack(r1_ack),
    .rdata(rdata),
    .mc_request(mc_request),
    .mc_request_type(mc_request_type),
    .mc_request_address(mc_request_address),
    .mc_memory_write(mc_memory_write),
    .mc_data_out(mc_data_out),
    .mc_memory_ready(mc_memory_ready),
    .mc_write_complete(mc_write_complete),
    .grant(grant),
    .busy(busy)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected or missing (cycle %0d)", name, cyc);
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Arbitration rules: single requester wins; lock keeps port 0; ties alternate.
  function automatic int pick(input bit q0, input bit q1, input bit lk);
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (lk && model_last == 0) return 0;
    return 1 - model_last;
  endfunction

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // mode 0: normal, 1: no completion and no ack (reset test), 2: watchdog expiry
  task automatic run_txn(input bit q0, input bit q1, input bit lk,
                         input bit t0, input bit t1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] d, input int lat, input bit spur,
                         input int mode);
    int    w;
    ctrl_t c;
    exp_t  e;
    bit    ok;
    r0_req = q0; r1_req = q1; r0_lock = lk;
    r0_type = t0; r1_type = t1;
    r0_addr = a0; r1_addr = a1;
    r0_wdata = w0; r1_wdata = w1;
    w = pick(q0, q1, lk);
    c.port = w;
    c.typ = (w == 1) ? t1 : t0;
    c.addr = (w == 1) ? a1 : a0;
    c.wdata = (w == 1) ? w1 : w0;
    c.rdata = d;
    c.lat = lat;
    c.hang = (mode != 0);
    c.spur = spur;
    c.issue_cyc = cyc + 2;
    ctrl_q.push_back(c);
    if (mode != 1) begin
      if (mode == 2) begin
        model_rdata = 16'h0000;
        done_q.push_back(c.issue_cyc + TO_CYC - 1);
      end else if (!c.typ) begin
        model_rdata = d;
      end
      e.port = w;
      e.rdata = model_rdata;
      exp_q.push_back(e);
      model_last = w;
      wait_ack(ok);
      if (!ok) begin
        flag("ack_timeout");
        finish_run();
      end
      @(posedge clk);
      @(negedge clk);
      r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0;
    end
  endtask

  // Controller model: answers requests and checks the held request fields.
  initial begin : controller
    ctrl_t it;
    bit    active;
    bit    fired;
    int    lat;
    int    low_run;
    active = 1'b0; fired = 1'b0; lat = 0; low_run = 100;
    mc_memory_ready = 1'b0; mc_write_complete = 1'b0; mc_data_out = 16'h0000;
    forever begin
      @(negedge clk);
      mc_memory_ready = 1'b0;
      mc_write_complete = 1'b0;
      if (!reset) begin
        active = 1'b0;
      end else if (!mc_request) begin
        if (active && !fired && !it.hang) flag("req_dropped_early");
        active = 1'b0;
        low_run++;
      end else begin
        if (!active) begin
          if (ctrl_q.size() == 0) begin
            flag("unexpected_request");
          end else begin
            it = ctrl_q.pop_front();
            active = 1'b1;
            fired = 1'b0;
            lat = it.lat;
            chk("issue_cycle", 32'(cyc), 32'(it.issue_cyc));
            chk("req_gap_ge2", 32'(low_run >= 2), 32'h1);
          end
          low_run = 0;
        end
        if (active) begin
          chk("mc_type", 32'(mc_request_type), 32'(it.typ));
          chk("mc_addr", 32'(mc_request_address), 32'(it.addr));
          chk("mc_wdata", 32'(mc_memory_write), 32'(it.wdata));
          chk("grant_wait", 32'(grant), (it.port == 1) ? 32'h2 : 32'h1);
          chk("busy_wait", 32'(busy), 32'h1);
          if (fired) begin
            flag("req_held_after_done");
          end else if (lat == 0 && !it.hang) begin
            if (it.typ) begin
              mc_write_complete = 1'b1;
              mc_data_out = 16'($urandom);
            end else begin
              mc_memory_ready = 1'b1;
              mc_data_out = it.rdata;
            end
            if ($urandom_range(0, 1) == 0) begin
              mc_memory_ready = 1'b1;
              mc_write_complete = 1'b1;
            end
            fired = 1'b1;
            done_q.push_back(cyc);
          end else begin
            if (it.spur || $urandom_range(0, 2) == 0) begin
              if (it.typ) mc_memory_ready = 1'b1;
              else mc_write_complete = 1'b1;
            end
            mc_data_out = 16'($urandom);
            if (lat > 0) lat--;
          end
        end
      end
    end
  end

  // Monitor: every ack pops one prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (r0_ack || r1_ack)) begin
        chk("ack_onehot", 32'(r0_ack && r1_ack), 32'h0);
        if (exp_q.size() == 0) begin
          flag("unexpected_ack");
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", 32'(r1_ack), 32'(e.port));
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("grant_at_ack", 32'(grant), (e.port == 1) ? 32'h2 : 32'h1);
          chk("mc_req_low_at_ack", 32'(mc_request), 32'h0);
          if (done_q.size() == 0) flag("ack_without_completion");
          else chk("ack_cycle", 32'(cyc), 32'(done_q.pop_front() + 1));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    flag("global_timeout");
    finish_run();
  end

  initial begin : stimulus
    bit q0, q1, lk, ok;
    reset = 1'b0;
    r0_req = 1'b0; r0_type = 1'b0; r0_addr = '0; r0_wdata = '0; r0_lock = 1'b0;
    r1_req = 1'b0; r1_type = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mc_request", 32'(mc_request), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_acks", 32'({r0_ack, r1_ack}), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_mc_addr", 32'(mc_request_address), 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
`endif
    #2 reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single read: completion 4 cycles after issue, ack one cycle later.
    run_txn(1, 0, 0, 0, 0, 16'h0123, 16'h0000, 16'h1111, 16'h0000, 16'hBEEF, 4, 0, 0);

    // Round-robin ties.
    for (int n = 0; n < 4; n++)
      run_txn(1, 1, 0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 5), 0, 0);

    // Lock keeps port 0, then releasing it hands the next tie to port 1.
    for (int n = 0; n < 3; n++)
      run_txn(1, 1, 1, 0, 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), $urandom_range(0, 5), 0, 0);
    run_txn(1, 1, 0, 0, 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 2, 0, 0);

    // Port 1 write with wrong-type ready pulses while waiting.
    run_txn(0, 1, 0, 0, 1, 16'h0000, 16'h0010, 16'h0000, 16'h5A5A, 16'h1234, 5, 1, 0);

    // Randomised traffic with occasional idle gaps.
    for (int n = 0; n < 40; n++) begin
      q0 = 1'($urandom);
      q1 = 1'($urandom);
      if (!q0 && !q1) q1 = 1'b1;
      lk = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(q0, q1, lk, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 6),
              1'($urandom), 0);
    end

    // Reset while waiting on the controller.
    run_txn(1, 0, 0, 0, 0, 16'h0777, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1000, 0, 1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mc_request) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_reached_wait", 32'(ok), 32'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_mc_request", 32'(mc_request), 32'h0);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_acks", 32'({r0_ack, r1_ack}), 32'h0);
    r0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    model_last = 1;
    model_rdata = 16'h0000;
    @(negedge clk);
    run_txn(1, 1, 0, 0, 1, 16'h0200, 16'h0300, 16'h0000, 16'h0000, 16'h4321, 3, 0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    chk("terr_before", 32'(timeout_err), 32'h0);
    run_txn(1, 0, 0, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 16'hDEAD, 1000, 0, 2);
    chk("terr_set", 32'(timeout_err), 32'h1);
    run_txn(1, 0, 0, 0, 0, 16'h0043, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 2, 0, 0);
    chk("terr_sticky", 32'(timeout_err), 32'h1);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("ctrl_q_drained", 32'(ctrl_q.size()), 32'h0);
    finish_run();
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Two-port arbiter that shares the single memory_controller_arduino request port between the x3q16 CPU (port 0) and a UART program loader (port 1). It serialises transactions, holds the controller request until the controller signals completion, then returns read data and an acknowledge pulse to the winning requester. It sits between the requesters and the memory controller in tt_um_zoom_zoom.

Parameters:
ADDR_W, 16, request address width
DATA_W, 16, read/write data width
FIXED_PRIORITY, 0, 1 = port 0 always wins; 0 = round-robin
TIMEOUT_CYCLES, 4096, watchdog limit in WAIT; used only with the optional feature

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
r0_req  input  1  port 0 request (CPU), level-sampled in IDLE
r0_type  input  1  0 = read, 1 = write
r0_addr  input  ADDR_W  port 0 address
r0_wdata  input  DATA_W  port 0 write data
r0_lock  input  1  port 0 keeps ownership across back-to-back transactions (memory_critical)
r0_ack  output  1  one-cycle completion pulse
r1_req  input  1  port 1 request (loader)
r1_type  input  1  0 = read, 1 = write
r1_addr  input  ADDR_W  port 1 address
r1_wdata  input  DATA_W  port 1 write data
r1_ack  output  1  one-cycle completion pulse
rdata  output  DATA_W  read data, shared, valid in the ack cycle
mc_request  output  1  to controller request
mc_request_type  output  1  to controller request_type
mc_request_address  output  ADDR_W  to controller request_address
mc_memory_write  output  DATA_W  to controller memory_write
mc_data_out  input  DATA_W  controller read data
mc_memory_ready  input  1  controller read complete
mc_write_complete  input  1  controller write complete
grant  output  2  one-hot current owner; 00 when idle
busy  output  1  high in ISSUE/WAIT/DONE

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0. last_grant = 1, so port 0 wins the first tie.
- The block has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - The block samples r0_req and r1_req.
  - When a winner is chosen, it latches that port's type, addr and wdata into registers and sets grant, then goes to ISSUE.
  - Requester inputs are ignored in every other state.
- Arbitration:
  - FIXED_PRIORITY = 1: port 0 wins.
  - FIXED_PRIORITY = 0: on a tie, the port other than last_grant wins.
  - Lock: if last_grant = 0, r0_lock = 1 and r0_req = 1, port 0 wins regardless of r1_req.
  - A single requester always wins.
- ISSUE: mc_request = 1 with the latched fields. Next state is WAIT. mc_request is registered, so it first goes high 1 cycle after the IDLE sample.
- WAIT:
  - mc_request and the latched fields are held stable.
  - Completion is mc_memory_ready when the latched type is 0, and mc_write_complete when it is 1. A completion of the wrong type is ignored. If both arrive together, only the matching one counts.
  - On completion: rdata <= mc_data_out for reads (unchanged for writes), mc_request <= 0, ack of the owner <= 1, last_grant <= owner, next state DONE.
- DONE: the ack pulse is high for exactly this cycle. mc_request = 0. grant is cleared on exit. Next state IDLE.
- Latency:
  - mc_request is low for at least 2 cycles between transactions.
  - The earliest re-issue is 3 cycles after the completion cycle.
- Requester rule: a requester must drop req in the cycle after it sees ack, or the still-high req is taken as a new transaction.
- rdata holds its value until the next read completes.
- Reset while in ISSUE or WAIT: mc_request drops immediately, with no ack. The requester must re-issue.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A 13-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the block goes to DONE with mc_request <= 0, owner ack = 1 and rdata <= 0.
  - It also sets the extra output port timeout_err, a sticky flag that is cleared only by reset.
  - A completion that arrives in the same cycle as expiry wins, with normal data and no error.
- Not defined: WAIT waits indefinitely, and the timeout_err port does not exist.

Test Plan:
- Single read: r0_req with type 0, addr 0x0123 at cycle 0. Expect mc_request = 1 at cycle 2 with address 0x0123. Controller returns mc_data_out = 0xBEEF with mc_memory_ready at cycle 6. Expect r0_ack = 1 and rdata = 0xBEEF at cycle 7, and mc_request = 0.
- Round-robin tie: r0_req and r1_req held high for 4 transactions with lock = 0. Expect grant sequence 01, 10, 01, 10 and mc_request low for at least 2 cycles between each.
- Lock: r0_lock = 1 with both ports requesting. Expect port 0 granted for 3 consecutive transactions. Dropping lock gives the next grant to port 1.
- Write with a spurious ready: port 1 write to addr 0x0010, wdata 0x5A5A. An mc_memory_ready pulse during WAIT is ignored. mc_write_complete then produces r1_ack. rdata is unchanged and mc_memory_write is 0x5A5A throughout WAIT.
- Reset mid-WAIT: assert reset low during WAIT. Expect mc_request, grant, busy and both acks all 0 immediately. After release, state is IDLE and port 0 wins the first tie.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16: read with no completion. Expect r0_ack and timeout_err = 1 after 16 WAIT cycles, rdata = 0, and timeout_err still 1 after the next normal transaction.
